// File: rtl/regbus_pkg.sv
// rtl/regbus_pkg.sv - shared types and defaults for the register-bus master arbiter
package regbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic RSP_ERR_NONE    = 1'b0;
  localparam logic RSP_ERR_TIMEOUT = 1'b1;

  localparam int DEF_NUM_MASTERS = 4;
  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_TIMEOUT_CYC = 15;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first requester at or after ptr
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any_req
);

  always_comb begin
    int unsigned j;
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    j         = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any_req && req[$clog2(N)'(j)]) begin
        any_req                = 1'b1;
        grant[$clog2(N)'(j)]   = 1'b1;
        grant_idx              = $clog2(N)'(j);
      end
    end
  end

endmodule

// File: rtl/regbus_master_arbiter.sv
// rtl/regbus_master_arbiter.sv - shares one register bus among NUM_MASTERS requesters,
// one single-beat write or read per grant, with read timeout.
module regbus_master_arbiter
  import regbus_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_MASTERS-1:0]        m_req_valid,
  input  logic [NUM_MASTERS-1:0]        m_req_write,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_req_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_req_wdata,
  output logic [NUM_MASTERS-1:0]        m_req_ready,
  output logic [NUM_MASTERS-1:0]        m_rsp_valid,
  output logic [DATA_W-1:0]             m_rsp_rdata,
  output logic                          m_rsp_err,
  output logic [ADDR_W-1:0]             addr,
  output logic                          chip_select,
  output logic                          write_en,
  output logic                          read_en,
  output logic [DATA_W-1:0]             write_data,
  input  logic [DATA_W-1:0]             read_data,
  input  logic                          data_valid
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_t                   state;
  logic [IDX_W-1:0]         rr_ptr;
  logic [IDX_W-1:0]         idx;
  logic [CNT_W-1:0]         cnt;
  logic [NUM_MASTERS-1:0]   grant;
  logic [IDX_W-1:0]         grant_idx;
  logic                     any_req;
  logic [ADDR_W-1:0]        sel_addr;
  logic [DATA_W-1:0]        sel_wdata;
  logic [NUM_MASTERS-1:0]   idx_oh;

  rr_arbiter #(.N(NUM_MASTERS)) u_rr_arbiter (
    .req       (m_req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  // Ready is gated by rst_n so nothing is accepted while reset is held.
  assign m_req_ready = (state == ST_IDLE && rst_n) ? grant : '0;
  assign sel_addr    = m_req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
  assign sel_wdata   = m_req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
  assign idx_oh      = NUM_MASTERS'(1) << idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      idx         <= '0;
      cnt         <= '0;
      m_rsp_valid <= '0;
      m_rsp_rdata <= '0;
      m_rsp_err   <= 1'b0;
      addr        <= '0;
      chip_select <= 1'b0;
      write_en    <= 1'b0;
      read_en     <= 1'b0;
      write_data  <= '0;
    end else begin
      m_rsp_valid <= '0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            idx         <= grant_idx;
            addr        <= sel_addr;
            chip_select <= 1'b1;
            cnt         <= '0;
            if (m_req_write[grant_idx]) begin
              write_en   <= 1'b1;
              write_data <= sel_wdata;
              state      <= ST_WRITE;
            end else begin
              read_en <= 1'b1;
              state   <= ST_READ;
            end
          end
        end
        ST_WRITE: begin
          chip_select <= 1'b0;
          write_en    <= 1'b0;
          m_rsp_valid <= idx_oh;
          m_rsp_rdata <= '0;
          m_rsp_err   <= RSP_ERR_NONE;
          state       <= ST_RESP;
        end
        ST_READ: begin
          // data_valid takes priority over a timeout landing on the same cycle
          if (data_valid) begin
            chip_select <= 1'b0;
            read_en     <= 1'b0;
            m_rsp_valid <= idx_oh;
            m_rsp_rdata <= read_data;
            m_rsp_err   <= RSP_ERR_NONE;
            state       <= ST_RESP;
          end else if (cnt == CNT_W'(TIMEOUT_CYC)) begin
            chip_select <= 1'b0;
            read_en     <= 1'b0;
            m_rsp_valid <= idx_oh;
            m_rsp_rdata <= '0;
            m_rsp_err   <= RSP_ERR_TIMEOUT;
            state       <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          rr_ptr <= (idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : idx + 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regbus_master_arbiter.sv
// tb/tb_regbus_master_arbiter.sv - self-checking bench for regbus_master_arbiter
module tb_regbus_master_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 15;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    m_req_valid = '0;
  logic [N-1:0]    m_req_write = '0;
  logic [N*AW-1:0] m_req_addr = '0;
  logic [N*DW-1:0] m_req_wdata = '0;
  logic [N-1:0]    m_req_ready;
  logic [N-1:0]    m_rsp_valid;
  logic [DW-1:0]   m_rsp_rdata;
  logic            m_rsp_err;
  logic [AW-1:0]   addr;
  logic            chip_select;
  logic            write_en;
  logic            read_en;
  logic [DW-1:0]   write_data;
  logic [DW-1:0]   read_data;
  logic            data_valid;

  int checks = 0;
  int errors = 0;

  // Slave model: raises data_valid slave_lat cycles after read_en first goes high.
  int            slave_lat = 1;
  logic [DW-1:0] rd_seed = '0;
  logic [7:0]    rd_cnt;

  int            mptr;
  logic [AW-1:0] a_v [N];
  logic [DW-1:0] d_v [N];

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rd_cnt <= '0;
    else if (read_en) rd_cnt <= rd_cnt + 8'd1;
    else              rd_cnt <= '0;
  end

  assign data_valid = read_en && (int'(rd_cnt) == slave_lat);
  assign read_data  = rd_seed ^ {{(DW-AW){1'b0}}, addr};

  regbus_master_arbiter #(
    .NUM_MASTERS (N),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m_req_valid (m_req_valid),
    .m_req_write (m_req_write),
    .m_req_addr  (m_req_addr),
    .m_req_wdata (m_req_wdata),
    .m_req_ready (m_req_ready),
    .m_rsp_valid (m_rsp_valid),
    .m_rsp_rdata (m_rsp_rdata),
    .m_rsp_err   (m_rsp_err),
    .addr        (addr),
    .chip_select (chip_select),
    .write_en    (write_en),
    .read_en     (read_en),
    .write_data  (write_data),
    .read_data   (read_data),
    .data_valid  (data_valid)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n       = 1'b0;
    m_req_valid = '0;
    mptr        = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Serve every master in vmask; expected order comes from scanning pending masters from mptr.
  task automatic run_round(input logic [N-1:0] vmask, input logic [N-1:0] wmask);
    int       order[$];
    logic [N-1:0] pend;
    logic [N-1:0] seen;
    int       p, cyc, acc, cur, w, exp_lat, exp_re, we_n, re_n;
    bit       active, is_wr, to_hit;
    logic [DW-1:0] exp_rdata;

    pend = vmask;
    p    = mptr;
    while (pend != '0) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (p + k) % N;
        if (pend[j]) begin
          order.push_back(j);
          pend[j] = 1'b0;
          p       = (j + 1) % N;
          break;
        end
      end
    end
    mptr = p;

    for (int i = 0; i < N; i++) begin
      m_req_addr[i*AW +: AW]  = a_v[i];
      m_req_wdata[i*DW +: DW] = d_v[i];
      m_req_write[i]          = wmask[i];
    end
    m_req_valid = vmask;

    cyc = 0; cur = 0; active = 0; acc = 0; exp_lat = 0; exp_re = 0;
    we_n = 0; re_n = 0; is_wr = 0; exp_rdata = '0;
    while (cur < order.size() && cyc < 300) begin
      @(negedge clk);
      w    = order[cur];
      seen = '0;
      chk("strobe_excl", {63'b0, write_en & read_en}, 64'd0);
      if (!active) begin
        chk("no_rsp_idle", {60'b0, m_rsp_valid}, 64'd0);
        if (m_req_ready != '0) begin
          chk("grant", {60'b0, m_req_ready}, {60'b0, oh(w)});
          seen   = m_req_ready;
          active = 1;
          acc    = cyc;
          we_n   = 0;
          re_n   = 0;
          is_wr  = wmask[w];
          to_hit = !is_wr && (slave_lat > TO);
          exp_lat   = is_wr ? 2 : (to_hit ? TO + 2 : slave_lat + 2);
          exp_re    = is_wr ? 0 : (to_hit ? TO + 1 : slave_lat + 1);
          exp_rdata = (is_wr || to_hit) ? '0 : (rd_seed ^ {{(DW-AW){1'b0}}, a_v[w]});
        end
      end else begin
        chk("ready_busy", {60'b0, m_req_ready}, 64'd0);
        if (write_en) we_n++;
        if (read_en)  re_n++;
        if (cyc == acc + 1) begin
          chk("bus_addr", {56'b0, addr}, {56'b0, a_v[w]});
          chk("bus_cs", {63'b0, chip_select}, 64'd1);
          if (is_wr) chk("bus_wdata", {32'b0, write_data}, {32'b0, d_v[w]});
        end
        if (m_rsp_valid != '0 || cyc >= acc + exp_lat) begin
          chk("rsp_valid", {60'b0, m_rsp_valid}, {60'b0, oh(w)});
          chk("rsp_latency", 64'(cyc - acc), 64'(exp_lat));
          chk("rsp_rdata", {32'b0, m_rsp_rdata}, {32'b0, exp_rdata});
          chk("rsp_err", {63'b0, m_rsp_err}, {63'b0, to_hit});
          chk("we_cycles", 64'(we_n), is_wr ? 64'd1 : 64'd0);
          chk("re_cycles", 64'(re_n), 64'(exp_re));
          chk("resp_strobes", {61'b0, chip_select, write_en, read_en}, 64'd0);
          cur++;
          active = 0;
        end
      end
      @(posedge clk);
      #1;
      m_req_valid = m_req_valid & ~seen;
      cyc++;
    end
    if (cur < order.size()) chk("round_timeout", 64'(cur), 64'(order.size()));
    m_req_valid = '0;
  endtask

  initial begin
    int lats[7];
    lats = '{1, 2, 5, 14, 15, 16, 255};

    // Reset state, with every master requesting during reset.
    m_req_valid = '1;
    mptr        = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {60'b0, m_req_ready}, 64'd0);
    chk("rst_rsp", {60'b0, m_rsp_valid}, 64'd0);
    chk("rst_rdata_err", {31'b0, m_rsp_rdata, m_rsp_err}, 64'd0);
    chk("rst_bus", {53'b0, addr, chip_select, write_en, read_en}, 64'd0);
    chk("rst_wdata", {32'b0, write_data}, 64'd0);
    m_req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single write from m0.
    a_v[0] = 8'h04; d_v[0] = 32'hA5A5_0001;
    run_round(4'b0001, 4'b0001);

    // Single read from m2, slave returns 0x1234_5678.
    a_v[2] = 8'h08; rd_seed = 32'h1234_5678 ^ 32'h08; slave_lat = 1;
    run_round(4'b0100, 4'b0000);

    // Fairness: all masters hold requests from a fresh reset, twice.
    do_reset();
    for (int i = 0; i < N; i++) begin a_v[i] = AW'(8'h10 + i); d_v[i] = $urandom; end
    rd_seed = $urandom;
    run_round(4'b1111, 4'b0101);
    run_round(4'b1111, 4'b1010);

    // Timeout, then the next grant must proceed normally.
    slave_lat = 255; a_v[1] = 8'h20;
    run_round(4'b0010, 4'b0000);
    slave_lat = 1; a_v[2] = 8'h24; d_v[2] = 32'hDEAD_BEEF;
    run_round(4'b0100, 4'b0100);

    // Timeout boundary: data_valid on the last cycle wins; one later times out.
    slave_lat = 15; rd_seed = 32'hCAFE_F00D; a_v[3] = 8'h30;
    run_round(4'b1000, 4'b0000);
    slave_lat = 14;
    run_round(4'b0001, 4'b0000);
    slave_lat = 16;
    run_round(4'b0010, 4'b0000);

    // Reset in the middle of a read.
    do_reset();
    slave_lat = 255; a_v[1] = 8'h40;
    m_req_addr[1*AW +: AW] = a_v[1];
    m_req_write = '0;
    m_req_valid = 4'b0010;
    for (int t = 0; t < 20 && !read_en; t++) @(negedge clk);
    chk("mid_read_started", {63'b0, read_en}, 64'd1);
    m_req_valid = '0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    mptr  = 0;
    #1;
    chk("mid_rst_bus", {53'b0, addr, chip_select, write_en, read_en}, 64'd0);
    chk("mid_rst_rsp", {60'b0, m_rsp_valid}, 64'd0);
    repeat (2) @(negedge clk);
    chk("mid_rst_hold", {59'b0, m_rsp_valid, read_en}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    slave_lat = 2; a_v[0] = 8'h50; a_v[3] = 8'h5C;
    run_round(4'b1001, 4'b0000);

    // Randomized rounds.
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < N; i++) begin a_v[i] = AW'($urandom); d_v[i] = $urandom; end
      rd_seed   = $urandom;
      slave_lat = lats[$urandom_range(0, 6)];
      run_round(N'($urandom_range(1, 15)), N'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
